pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 99 +++++++++
 tb/tb_pipe_reg_chain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline with collapsing
// bubbles. Stage 0 captures upstream entries and stage DEPTH-1 presents them
// downstream. Any stage can advance into an empty or simultaneously
// advancing successor, so gaps close up instead of travelling to the output.
// flush drops every held entry in one cycle. clr resets all registers
// asynchronously.
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [3:0]       occupancy
);

    // Per-stage state. Index 0 is the input side.
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];

    // Stage i hands its entry to stage i+1, or to downstream for the last stage.
    logic [DEPTH-1:0] w_adv;
    // Stage i loads a new entry this cycle.
    logic [DEPTH-1:0] w_recv;
    // Payload that stage i would load.
    logic [WIDTH-1:0] w_src [DEPTH];
    logic             w_accept;

    // The output comes straight from the last stage. flush hides it so that
    // nothing leaves during a discard cycle.
    assign out_valid = r_v[DEPTH-1] & ~flush;
    assign out_data  = r_d[DEPTH-1];

    // Compute the advance chain from the output side back towards the input.
    // A stage moves when it holds an entry and its successor is free or is
    // moving in the same cycle. flush blocks every transfer.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = out_valid & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = ~flush & r_v[i] & (~r_v[i+1] | w_adv[i+1]);
        end
    end

    assign in_ready = ~flush & (~r_v[0] | w_adv[0]);
    assign w_accept = in_valid & in_ready;

    // Decide, per stage, where its next entry comes from.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_src
        if (gi == 0) begin : g_head
            assign w_recv[gi] = w_accept;
            assign w_src[gi]  = in_data;
        end else begin : g_body
            assign w_recv[gi] = w_adv[gi-1];
            assign w_src[gi]  = r_d[gi-1];
        end
    end

    // Update the stage registers.
    // Receiving takes priority over emptying, because a stage that passes
    // its entry on and takes a new one in the same cycle stays full.
    // Data registers load only when a stage receives an entry, so flush
    // leaves stale payloads behind. Those payloads are never presented
    // because their valid bits are clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            r_v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_recv[i]) begin
                    r_v[i] <= 1'b1;
                    r_d[i] <= w_src[i];
                end else if (w_adv[i]) begin
                    r_v[i] <= 1'b0;
                end
            end
        end
    end

    // Count the set valid bits to give the number of held entries.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {3'b000, r_v[i]};
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain with DEPTH=3 and
// WIDTH=32. Each accepted entry goes into a queue, and each entry the DUT
// presents is popped from the queue and compared. After every edge the
// occupancy output is compared with the queue length.
module tb_pipe_reg_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic             clk;
    logic             clr;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [3:0]       occupancy;

    logic [WIDTH-1:0] sb_q [$];
    int               n_chk;
    int               n_pass;

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop the run with a FAIL line if it takes far longer than it should.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one clock cycle. Call it at a falling edge with the inputs already
    // driven. Handshakes are sampled before the rising edge and occupancy is
    // checked at the next falling edge.
    task automatic step();
        logic acc;
        logic pop;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        $display("t=%0t acc=%0d in=0x%08h pop=%0d out=0x%08h flush=%0d occ=%0d",
                 $time, acc, in_data, pop, out_data, flush, occupancy);
        if (pop) begin
            if (sb_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
            else                  chk("out_data", 64'(out_data), 64'(sb_q.pop_front()));
        end
        if (acc)   sb_q.push_back(in_data);
        if (flush) sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        clr       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Outputs during reset.
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_occ",       64'(occupancy), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        flush = 1'b1;
        #1;
        chk("rst_flush_rdy", 64'(in_ready),  64'(0));
        flush = 1'b0;
        // An offer that spans an edge while clr is high must not be accepted.
        in_valid = 1'b1;
        in_data  = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept", 64'(occupancy), 64'(0));
        in_valid = 1'b0;
        clr      = 1'b0;

        // Latency: one entry takes DEPTH hops.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        #1;
        chk("lat_in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk("lat_ov_e0", 64'(out_valid), 64'(0));
        step();
        chk("lat_ov_e1", 64'(out_valid), 64'(0));
        step();
        chk("lat_ov_e2", 64'(out_valid), 64'(1));
        chk("lat_od_e2", 64'(out_data),  64'(32'hA5));
        step();

        // Back-to-back stream with the sink always ready.
        for (int v = 1; v <= 16; v++) begin
            in_valid = 1'b1;
            in_data  = 32'(v);
            #1;
            chk("thr_in_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_valid = 1'b0;
        repeat (DEPTH + 1) step();
        chk("thr_drained", 64'(sb_q.size()), 64'(0));

        // Fill while the sink stalls, then drain and fill in the same cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hB0 + 32'(k);
            #1;
            chk("fill_in_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_data = 32'hB3;
        #1;
        chk("full_in_ready", 64'(in_ready),  64'(0));
        chk("full_occ",      64'(occupancy), 64'(3));
        step();
        chk("stall_out_data", 64'(out_data), 64'(32'hB0));
        out_ready = 1'b1;
        #1;
        chk("drain_fill_rdy", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        repeat (DEPTH + 1) step();
        chk("order_drained", 64'(sb_q.size()), 64'(0));

        // Flush overrides a simultaneous offer and downstream ready.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hC1 + 32'(k);
            step();
        end
        in_data   = 32'hC3;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready),  64'(0));
        chk("flush_ov",       64'(out_valid), 64'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ov_after", 64'(out_valid), 64'(0));
        chk("flush_occ",      64'(occupancy), 64'(0));
        repeat (DEPTH) step();

        // Asynchronous clear while the pipe is full.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hD1 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        chk("aclr_ov",  64'(out_valid), 64'(0));
        chk("aclr_od",  64'(out_data),  64'(0));
        chk("aclr_occ", 64'(occupancy), 64'(0));
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        clr       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3C;
        #1;
        chk("aclr_rel_rdy", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk("aclr_ov_e0", 64'(out_valid), 64'(0));
        step();
        chk("aclr_ov_e1", 64'(out_valid), 64'(0));
        step();
        chk("aclr_ov_e2", 64'(out_valid), 64'(1));
        chk("aclr_od_e2", 64'(out_data),  64'(32'h3C));
        step();

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();
        chk("rand_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
